// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers (read and write side).
// Pointers carry one extra MSB so that a full FIFO can be told apart from an empty one.
package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer, empty/almost-empty, occupancy and sticky underflow status
// for the depth-8 async FIFO; rq_wptr_gray arrives already synchronised to clk.
module fifo_rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rq_wptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PTR_W-1:0]  rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  rd_count,
  output logic              underflow
);

  ptr_t r_rbin;
  ptr_t r_rgray;
  ptr_t r_count;
  logic r_empty;
  logic r_aempty;
  logic r_underflow;

  logic w_pop;
  ptr_t w_rbin_next;
  ptr_t w_rgray_next;
  ptr_t w_wbin;
  ptr_t w_cnt_next;

  // Status is evaluated on the post-pop pointer so that a pop of the last entry
  // coinciding with a new write keeps empty low and the count steady.
  // NOTE: every signal written in always_comb gets a value on all paths; a
  // missing default here would infer a latch.
  always_comb begin
    w_pop        = rd_en & ~r_empty;
    w_rbin_next  = r_rbin + PTR_W'(w_pop);
    w_rgray_next = bin2gray(w_rbin_next);
    w_wbin       = gray2bin(rq_wptr_gray);
    w_cnt_next   = w_wbin - w_rbin_next;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rgray     <= w_rgray_next;
      r_count     <= w_cnt_next;
      r_empty     <= (w_rgray_next == rq_wptr_gray);
      r_aempty    <= (w_cnt_next <= PTR_W'(AEMPTY_TH));
      r_underflow <= r_underflow | (rd_en & r_empty);
    end
  end

  assign rd_addr      = r_rbin[ADDR_W-1:0];
  assign rd_ptr_gray  = r_rgray;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign rd_count     = r_count;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Directed and random checks of fifo_rd_ptr_empty against a model that tracks
// total writes and total pops as plain integers.
module tb_fifo_rd_ptr_empty;

  logic       clk;
  logic       nrst;
  logic       rd_en;
  logic [3:0] rq_wptr_gray;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  fifo_rd_ptr_empty dut (
    .clk          (clk),
    .nrst         (nrst),
    .rd_en        (rd_en),
    .rq_wptr_gray (rq_wptr_gray),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: counts of entries written and popped since reset.
  int   wr_n, rd_n, exp_count;
  logic exp_empty, exp_aempty, exp_uf;
  logic [3:0] prev_gray;

  function automatic logic [3:0] gray_of(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_addr"},      32'(rd_addr),      32'(rd_n % 8));
    check({tag, ".rd_ptr_gray"},  32'(rd_ptr_gray),  32'(gray_of(rd_n)));
    check({tag, ".empty"},        32'(empty),        32'(exp_empty));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(exp_aempty));
    check({tag, ".rd_count"},     32'(rd_count),     32'(exp_count));
    check({tag, ".underflow"},    32'(underflow),    32'(exp_uf));
  endtask

  task automatic model_reset();
    wr_n = 0; rd_n = 0; exp_count = 0;
    exp_empty = 1'b1; exp_aempty = 1'b1; exp_uf = 1'b0;
    prev_gray = 4'd0;
  endtask

  // One read clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic step(input string tag, input logic ren, input logic winc);
    logic pop;
    rd_en = ren;
    if (winc) wr_n++;
    rq_wptr_gray = gray_of(wr_n);
    @(posedge clk);
    pop = ren && !exp_empty;
    if (ren && exp_empty) exp_uf = 1'b1;
    if (pop) rd_n++;
    exp_count  = wr_n - rd_n;
    exp_empty  = (exp_count == 0);
    exp_aempty = (exp_count <= 1);
    #1;
    check_all(tag);
    check({tag, ".occ_legal"}, 32'(exp_count <= 8), 32'd1);
    check({tag, ".gray_hamming"}, 32'($countones(prev_gray ^ rd_ptr_gray) <= 1), 32'd1);
    prev_gray = rd_ptr_gray;
  endtask

  initial begin
    nrst = 1'b0;
    rd_en = 1'b0;
    rq_wptr_gray = 4'd0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    nrst = 1'b1;

    // Two entries become visible, then are popped.
    wr_n = 2;
    step("two_vis", 1'b0, 1'b0);
    step("pop1", 1'b1, 1'b0);
    step("pop2", 1'b1, 1'b0);

    // Underflow: pop while empty, then stays sticky through idle clocks.
    step("uf_pop", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step("uf_idle", 1'b0, 1'b0);

    // Reset mid-run, asserted between edges; write side resets too.
    step("pre_rst", 1'b0, 1'b1);
    #2;
    nrst = 1'b0;
    rd_en = 1'b0;
    rq_wptr_gray = 4'd0;
    model_reset();
    #1;
    check("rst_mid.empty",       32'(empty),       32'd1);
    check("rst_mid.rd_count",    32'(rd_count),    32'd0);
    check("rst_mid.rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    check("rst_mid.underflow",   32'(underflow),   32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Full FIFO, then drain to a single entry.
    wr_n = 8;
    step("full", 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("drain", 1'b1, 1'b0);

    // Pop of the last entry with a coincident write.
    step("same_cyc", 1'b1, 1'b1);

    // Wrap: 16 pops with the writer one step ahead each clock.
    for (int i = 0; i < 16; i++) step("wrap", 1'b1, 1'b1);

    // Random traffic with a legal writer (at most 8 outstanding).
    for (int i = 0; i < 400; i++) begin
      logic ren, winc;
      ren  = 1'($urandom_range(0, 1));
      winc = ($urandom_range(0, 99) < 55) && (wr_n - rd_n < 8);
      step("rand", ren, winc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
